// File: rtl/pwm_frame_scheduler.sv
// pwm_frame_scheduler
//   Feeds pwm_audio one sample per PWM frame. Producer samples are buffered in a
//   small FIFO. This block owns the frame counter, and the FIFO head is presented
//   only at frame boundaries, so the PWM comparator never sees a mid-period change.
//   Start-up priming, underrun recovery and mute/flush are handled here.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       1 = play, 0 = mute and flush
//   s_valid      producer sample valid
//   s_data       producer sample (unsigned offset-binary)
//   s_ready      FIFO can accept a sample (registered)
//   sample       sample presented to pwm_audio, changes only after frame_tick
//   frame_tick   one-cycle pulse on the last cycle of every frame
//   fifo_level   current FIFO occupancy
//   underrun_cnt saturating count of starved frames
//   state        0 IDLE, 1 PRIME, 2 RUN
module pwm_frame_scheduler #(
    parameter int unsigned PERIOD   = 4095,
    parameter int unsigned DW       = 12,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MIDSCALE = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   s_valid,
    input  logic [DW-1:0]          s_data,
    output logic                   s_ready,
    output logic [DW-1:0]          sample,
    output logic                   frame_tick,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            underrun_cnt,
    output logic [1:0]             state
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_HALF = LW'(DEPTH / 2);
    localparam logic [DW-1:0] MID      = DW'(MIDSCALE);
    localparam logic [15:0]   UR_MAX   = 16'hFFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Storage and pointers
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Next-state values
    logic [1:0]    state_n;
    logic [AW-1:0] wr_ptr_n;
    logic [AW-1:0] rd_ptr_n;
    logic [LW-1:0] level_n;
    logic [DW-1:0] sample_n;
    logic [15:0]   underrun_n;
    logic [CW-1:0] cnt_n;
    logic          tick_n;
    logic          ready_n;
    logic          push_c;
    logic          pop_c;

    // Frame counter: free-running in every state; the tick flag is registered
    // alongside it so frame_tick is high exactly while cnt == PERIOD-1.
    always_comb begin
        cnt_n  = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        tick_n = (cnt_n == CNT_LAST);
    end

    // Next-state, FIFO bookkeeping and sample update
    always_comb begin
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        level_n    = fifo_level;
        sample_n   = sample;
        underrun_n = underrun_cnt;
        pop_c      = 1'b0;
        push_c     = s_valid && s_ready && (state != ST_IDLE);

        if (!enable) begin
            // Mute: flush at once; the output only falls to silence on a tick.
            state_n  = ST_IDLE;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            level_n  = '0;
            if (frame_tick) begin
                sample_n = MID;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_PRIME;
                    if (frame_tick) begin
                        sample_n = MID;
                    end
                end
                ST_PRIME: begin
                    // Wait for half a FIFO of headroom before starting playback.
                    if (frame_tick && (fifo_level >= LVL_HALF)) begin
                        pop_c    = 1'b1;
                        sample_n = mem[rd_ptr];
                        state_n  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pop decision uses the registered level, so a push that lands
                    // on this same tick cannot rescue an empty FIFO.
                    if (frame_tick) begin
                        if (fifo_level != '0) begin
                            pop_c    = 1'b1;
                            sample_n = mem[rd_ptr];
                        end else begin
                            state_n = ST_PRIME;
                            if (underrun_cnt != UR_MAX) begin
                                underrun_n = underrun_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            if (push_c) begin
                wr_ptr_n = wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_n = rd_ptr + AW'(1);
            end
            if (push_c && !pop_c) begin
                level_n = fifo_level + LW'(1);
            end else if (pop_c && !push_c) begin
                level_n = fifo_level - LW'(1);
            end
        end

        // Ready is registered from the next-cycle view so it is never high while full.
        ready_n = (state_n != ST_IDLE) && (level_n != LVL_FULL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            sample       <= MID;
            underrun_cnt <= '0;
            cnt          <= '0;
            frame_tick   <= 1'b0;
            s_ready      <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            fifo_level   <= level_n;
            sample       <= sample_n;
            underrun_cnt <= underrun_n;
            cnt          <= cnt_n;
            frame_tick   <= tick_n;
            s_ready      <= ready_n;
        end
    end

    // Sample storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Testbench for pwm_frame_scheduler (PERIOD=16, DEPTH=4, MIDSCALE=2048).
// A queue-based model predicts every output each cycle; directed literal checks
// pin the key scenario values.
module tb_pwm_frame_scheduler;

    localparam int PERIOD = 16;
    localparam int DEPTH  = 4;
    localparam int MID    = 2048;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        s_valid;
    logic [11:0] s_data;
    logic        s_ready;
    logic [11:0] sample;
    logic        frame_tick;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_cnt;
    logic [1:0]  state;

    pwm_frame_scheduler #(
        .PERIOD  (PERIOD),
        .DW      (12),
        .DEPTH   (DEPTH),
        .MIDSCALE(MID)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .sample      (sample),
        .frame_tick  (frame_tick),
        .fifo_level  (fifo_level),
        .underrun_cnt(underrun_cnt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    bit          m_valid = 1'b0;
    int          m_cnt   = 0;
    int          m_state = 0;
    int          m_under = 0;
    bit          m_ready = 1'b0;
    logic [11:0] m_sample = 12'd2048;
    logic [11:0] q[$];

    // Capture of sample on cycle 0 of each frame
    bit          capture_en = 1'b0;
    logic [11:0] got[$];
    int          maxlvl = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: frame counter plus a queue, advanced on every clock edge.
    initial begin
        bit tick;
        bit do_push;
        int nxt;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt    = 0;
                m_state  = 0;
                m_under  = 0;
                m_ready  = 1'b0;
                m_sample = 12'd2048;
                q.delete();
                m_valid  = 1'b1;
            end else begin
                tick    = (m_cnt == PERIOD - 1);
                do_push = s_valid && m_ready && (m_state != 0);
                if (!enable) begin
                    if (tick) m_sample = 12'd2048;
                    q.delete();
                    m_state = 0;
                end else begin
                    nxt = m_state;
                    if (m_state == 0) begin
                        nxt = 1;
                        if (tick) m_sample = 12'd2048;
                    end else if (tick) begin
                        if (m_state == 1 && q.size() >= DEPTH / 2) begin
                            m_sample = q.pop_front();
                            nxt = 2;
                        end else if (m_state == 2) begin
                            if (q.size() > 0) begin
                                m_sample = q.pop_front();
                            end else begin
                                if (m_under < 65535) m_under++;
                                nxt = 1;
                            end
                        end
                    end
                    if (do_push) q.push_back(s_data);
                    m_state = nxt;
                end
                m_ready = (m_state != 0) && (q.size() < DEPTH);
                m_cnt   = (m_cnt + 1) % PERIOD;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic exp_tick;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_tick = (m_cnt == PERIOD - 1);
                tests++;
                if (sample !== m_sample || frame_tick !== exp_tick ||
                    fifo_level !== 3'(q.size()) || s_ready !== m_ready ||
                    underrun_cnt !== 16'(m_under) || state !== 2'(m_state)) begin
                    fails++;
                    $display("FAIL model t=%0t: sample %0d/%0d tick %0b/%0b level %0d/%0d ready %0b/%0b under %0d/%0d state %0d/%0d",
                             $time, sample, m_sample, frame_tick, exp_tick, fifo_level, q.size(),
                             s_ready, m_ready, underrun_cnt, m_under, state, m_state);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (capture_en && m_cnt == 0) got.push_back(sample);
        if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    endtask

    task automatic wait_cnt(input int c);
        int g = 0;
        while (m_cnt != c && g < 2 * PERIOD) begin
            cyc();
            g++;
        end
    endtask

    task automatic push_one(input int val);
        int g = 0;
        while (!s_ready && g < 100) begin
            cyc();
            g++;
        end
        chk("push_ready", int'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 12'(val);
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sample"}, int'(sample), MID);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_ready"}, int'(s_ready), 0);
        chk({tag, "_under"}, int'(underrun_cnt), 0);
        chk({tag, "_tick"}, int'(frame_tick), 0);
    endtask

    // Directed stimulus
    initial begin
        int  v;
        int  g;
        int  ticks;
        bit  rdy;

        rst_n   = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        // Reset and idle
        repeat (5) cyc();
        chk_reset_values("rst");
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            if (frame_tick) ticks++;
        end
        chk("idle_ticks_in_32", ticks, 2);
        chk("idle_sample", int'(sample), MID);
        chk("idle_ready", int'(s_ready), 0);

        // Priming
        enable = 1'b1;
        cyc();
        chk("prime_state", int'(state), 1);
        push_one(100);
        push_one(200);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("prime_first_sample", int'(sample), 100);
        chk("prime_to_run", int'(state), 2);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("prime_second_sample", int'(sample), 200);

        // Backpressure: stream 1..9 with s_valid held high
        cyc();
        capture_en = 1'b1;
        got.delete();
        maxlvl = 0;
        v = 1;
        g = 0;
        s_valid = 1'b1;
        while (v <= 9 && g < 400) begin
            s_data = 12'(v);
            rdy = s_ready;
            cyc();
            if (rdy) v++;
            g++;
        end
        s_valid = 1'b0;
        chk("bp_all_accepted", v, 10);
        chk("bp_max_level", maxlvl, DEPTH);

        // Underrun after drain
        g = 0;
        while (got.size() < 10 && g < 400) begin
            cyc();
            g++;
        end
        capture_en = 1'b0;
        chk("bp_capture_count", got.size(), 10);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) chk($sformatf("bp_order_%0d", i), int'(got[i]), i + 1);
        end
        if (got.size() >= 10) chk("ur_hold_sample", int'(got[9]), 9);
        chk("ur_count", int'(underrun_cnt), 1);
        chk("ur_state", int'(state), 1);
        push_one(500);
        push_one(600);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("resume_sample", int'(sample), 500);
        chk("resume_state", int'(state), 2);

        // Mute with sample=300 and one entry still queued
        push_one(300);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("mute_pre_600", int'(sample), 600);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("mute_pre_300", int'(sample), 300);
        push_one(700);
        chk("mute_level_before", int'(fifo_level), 1);
        wait_cnt(5);
        enable = 1'b0;
        cyc();
        chk("mute_state", int'(state), 0);
        chk("mute_level", int'(fifo_level), 0);
        chk("mute_ready", int'(s_ready), 0);
        chk("mute_hold", int'(sample), 300);
        wait_cnt(PERIOD - 1);
        chk("mute_hold_tick", int'(sample), 300);
        cyc();
        chk("mute_midscale", int'(sample), MID);

        // Tick collision: push into empty FIFO on the tick while in RUN
        enable = 1'b1;
        cyc();
        push_one(10);
        push_one(20);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("col_sample_10", int'(sample), 10);
        wait_cnt(PERIOD - 1);
        cyc();
        chk("col_sample_20", int'(sample), 20);
        wait_cnt(PERIOD - 1);
        s_valid = 1'b1;
        s_data  = 12'd30;
        cyc();
        s_valid = 1'b0;
        chk("col_under", int'(underrun_cnt), 2);
        chk("col_level", int'(fifo_level), 1);
        chk("col_state", int'(state), 1);
        chk("col_sample_hold", int'(sample), 20);

        // Reset mid-frame
        wait_cnt(7);
        rst_n = 1'b0;
        cyc();
        chk_reset_values("midrst");
        rst_n = 1'b1;
        repeat (40) cyc();
        enable = 1'b0;
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
